// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_muldiv_iter_pkg;

    localparam int XLEN_DEFAULT = 32;

    // RV32M/RV64M funct3 encodings; bit 2 set means a divide-class op
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration on the {hi,lo} accumulator: shift-add for multiply, restoring trial-subtract for divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: is_div_i selects divide step, acc_i/acc_o 2*XLEN accumulator, opnd_i multiplicand or divisor magnitude.
module alu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: lo holds the not-yet-consumed multiplier bits, LSB first;
        // adding into hi then shifting right is the same as adding |a|<<i.
        mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: hi is the partial remainder, lo shifts dividend bits out
        // of its top while quotient bits enter at the bottom.
        rem_sh  = acc_i[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, opnd_i};
        acc_o   = {mul_sum, acc_i[XLEN-1:1]};
        if (is_div_i) begin
            if (!diff[XLEN]) begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one bit per clock.
// Latency: XLEN+2 edges accept-to-result (counting the accept edge); zero-divide and signed overflow in 1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush kills any op.
// Ports: clk/rst_n, flush, in_valid/in_ready/in_op/in_a/in_b/in_tag request, out_valid/out_ready/out_result/out_tag result.
module alu_muldiv_iter
    import alu_muldiv_iter_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    md_op_t            op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d, out_tag_q, out_tag_d;
    logic [XLEN-1:0]   res_q, res_d, opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Request conditioning
    md_op_t            req_op;
    logic              a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    // Result conditioning
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    alu_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_q[2]),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_tag    = out_tag_q;

    always_comb begin
        req_op   = md_op_t'(in_op);
        // Only the unsigned-a ops (MULHU/DIVU/REMU) treat rs1 as a magnitude;
        // rs2 is additionally unsigned for MULHSU.
        a_neg    = in_a[XLEN-1] && !(req_op inside {MD_MULHU, MD_DIVU, MD_REMU});
        b_neg    = in_b[XLEN-1] && (req_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
        div_zero = in_op[2] && (in_b == '0);
        div_ovf  = (req_op inside {MD_DIV, MD_REM}) && (in_a == XMIN) && (in_b == '1);

        prod     = neg_res_q ? -acc_q : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];

        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        out_tag_d = out_tag_q;
        res_d     = res_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d      = req_op;
                        tag_d     = in_tag;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        // Divide keeps the dividend in lo and the divisor as
                        // the step operand; multiply the other way round.
                        opnd_d    = in_op[2] ? b_mag : a_mag;
                        acc_d     = {{XLEN{1'b0}}, (in_op[2] ? a_mag : b_mag)};
                        if (div_zero || div_ovf) begin
                            state_d   = DONE;
                            out_tag_d = in_tag;
                            if (div_zero) begin
                                res_d = in_op[1] ? in_a : '1;
                            end else begin
                                res_d = in_op[1] ? '0 : in_a;
                            end
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    out_tag_d = tag_q;
                    unique case (op_q)
                        MD_MUL:                       res_d = prod[XLEN-1:0];
                        MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod[2*XLEN-1:XLEN];
                        MD_DIV, MD_DIVU:              res_d = neg_res_q ? -quo : quo;
                        default:                      res_d = neg_rem_q ? -rem : rem;
                    endcase
                    state_d = DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= MD_MUL;
            tag_q     <= '0;
            out_tag_q <= '0;
            res_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            out_tag_q <= out_tag_d;
            res_q     <= res_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Bench for alu_muldiv_iter at XLEN=32: directed vector table, multi-cycle corner sequences, random ops vs model.
// Latency: results checked for value, tag and accept-to-valid edge count.
// Backpressure: exercises out_ready stall, flush and asynchronous reset mid-operation.
module tb_alu_muldiv_iter;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int n_pass = 0;
    int n_total = 0;

    alu_muldiv_iter #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model straight from the ISA arithmetic rules
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_div, is_sdiv;
        is_div  = (op >= 3'd4);
        is_sdiv = (op == 3'd4) || (op == 3'd6);
        if (is_div && (b == 0 || (is_sdiv && a == MIN32 && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    // Issue one op from IDLE; returns at the first sample with out_valid high
    // (or after the cycle bound). lat counts edges including the accept edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res, output logic [4:0] otag,
                         output int lat, output bit ir_bad);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = 5'($urandom);
        lat      = 1;
        ir_bad   = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res  = out_result;
        otag = out_tag;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check(name, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    function automatic logic [31:0] corner_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN32;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [31:0] r, r0;
        logic [4:0]  t, t0;
        int          lat, bad;
        bit          irb;

        vt[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vt[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vt[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vt[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vt[6]  = '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 34};
        vt[7]  = '{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 34};
        vt[8]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vt[9]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vt[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vt[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vt[12] = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vt[13] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vt[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_state", 64'({in_ready, out_valid, out_result, out_tag}), 64'({1'b1, 1'b0, 32'd0, 5'd0}));
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, 5'(i + 3), r, t, lat, irb);
            check($sformatf("vec%0d_result", i), 64'(r), 64'(vt[i].exp));
            check($sformatf("vec%0d_tag", i), 64'(t), 64'(i + 3));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_in_ready_low", i), 64'(irb), 64'd0);
            handshake($sformatf("vec%0d_handshake", i));
        end

        // Result held while consumer stalls
        out_ready = 1'b0;
        do_op(3'd5, 32'd100, 32'd7, 5'd9, r0, t0, lat, irb);
        check("hold_first_result", 64'({r0, t0}), 64'({32'd14, 5'd9}));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_result !== r0 || out_tag !== t0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("hold_stable_10", 64'(bad), 64'd0);
        handshake("hold_release");

        // Flush at count=10 kills the op; next op accepted immediately after
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd12345; in_b = 32'd678; in_tag = 5'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) bad++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_to_idle", 64'({bad[0], out_valid, in_ready}), 64'(3'b001));
        do_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd21, r, t, lat, irb);
        check("post_flush_result", 64'({r, t}), 64'({32'hFFFF_FFFF, 5'd21}));
        check("post_flush_latency", 64'(lat), 64'd34);
        handshake("post_flush_handshake");

        // Flush wins over in_valid in IDLE
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd4; in_a = 32'd5; in_b = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid || !in_ready) bad++;
            @(posedge clk); #1;
        end
        check("flush_blocks_accept", 64'(bad), 64'd0);

        // Flush and out_ready together in DONE
        out_ready = 1'b0;
        do_op(3'd4, 32'd5, 32'd0, 5'd2, r, t, lat, irb);
        check("flush_done_setup", 64'({r, t}), 64'({32'hFFFF_FFFF, 5'd2}));
        flush = 1'b1;
        handshake("flush_in_done");
        flush = 1'b0;

        // Asynchronous reset in the middle of CALC
        in_valid = 1'b1; in_op = 3'd3; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_tag = 5'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_calc", 64'({out_valid, out_result, out_tag}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) bad++;
        end
        check("no_result_after_reset", 64'(bad), 64'd0);

        // Randomised ops against the model
        for (int i = 0; i < 250; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [4:0]  tg;
            op = 3'($urandom);
            a  = corner_val();
            b  = corner_val();
            tg = 5'($urandom);
            do_op(op, a, b, tg, r, t, lat, irb);
            check($sformatf("rand%0d_op%0d_a%0h_b%0h", i, op, a, b), 64'({r, t}), 64'({ref_res(op, a, b), tg}));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(op, a, b)));
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
